mem_read_responder: RTL and testbench



---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_lat_pipe.sv | 40 ++++
 rtl/mem_read_responder.sv | 68 ++++++
 tb/tb_mem_read_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared defaults and the pipeline stage record for the main-memory read responder.
package mem_pkg;

    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_LATENCY   = 4;
    localparam int DEF_MEM_WORDS = 65536 >> 1;

    // One slot of the read-latency pipeline; valid=0 marks a bubble.
    typedef struct packed {
        logic                  valid;
        logic [DEF_DATA_W-1:0] data;
    } stage_t;

endpackage

// File: rtl/mem_lat_pipe.sv
// Fixed-depth, non-stalling shift pipeline of {valid, data} records; the final stage is the output.
module mem_lat_pipe
    import mem_pkg::*;
#(
    parameter int DEPTH = DEF_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [DEF_DATA_W-1:0] req_data,
    output logic                  rsp_valid,
    output logic [DEF_DATA_W-1:0] rsp_data
);

    stage_t pipe [DEPTH];

    // Data only advances with a valid tag, so the last stage holds its value across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].valid <= req_valid;
            if (req_valid) begin
                pipe[0].data <= req_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i].valid <= pipe[i-1].valid;
                if (pipe[i-1].valid) begin
                    pipe[i].data <= pipe[i-1].data;
                end
            end
        end
    end

    assign rsp_valid = pipe[DEPTH-1].valid;
    assign rsp_data  = pipe[DEPTH-1].data;

endmodule

// File: rtl/mem_read_responder.sv
// Pipelined main-memory model: reads answered exactly LATENCY cycles later, writes complete at the request edge.
module mem_read_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int LATENCY   = DEF_LATENCY,
    parameter int MEM_WORDS = DEF_MEM_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [3:0]        inflight
);

    // Handshake: no backpressure. A request is taken on every edge where enable=1;
    // data_valid is a one-cycle strobe that the consumer must accept when it appears.

    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [DATA_W-1:0] mem [MEM_WORDS];
    logic [ADDR_W-2:0] word_addr;
    logic [IDX_W-1:0]  word_idx;
    logic              rd_accept;
    logic              wr_accept;

    assign word_addr = addr[ADDR_W-1:1];
    assign word_idx  = IDX_W'(32'(word_addr) % 32'(MEM_WORDS));
    assign rd_accept = enable && !wr;
    assign wr_accept = enable && wr;

    // Array is not reset: contents survive rst_n and are undefined at power-up.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[word_idx] <= data_in;
        end
    end

    // The read tag samples the array before any same-edge write lands.
    mem_lat_pipe #(
        .DEPTH (LATENCY)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (rd_accept),
        .req_data  (mem[word_idx]),
        .rsp_valid (data_valid),
        .rsp_data  (data_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            case ({rd_accept, data_valid})
                2'b10:   inflight <= inflight + 4'd1;
                2'b01:   inflight <= inflight - 4'd1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_read_responder.sv
// Directed bench for mem_read_responder: LATENCY=4 build plus a LATENCY=2 build fed the same requests.
module tb_mem_read_responder;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic [3:0]  inflight;
    logic [15:0] data_out2;
    logic        data_valid2;
    logic [3:0]  inflight2;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    mem_read_responder u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .inflight   (inflight)
    );

    mem_read_responder #(.LATENCY(2)) u_dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out2),
        .data_valid (data_valid2),
        .inflight   (inflight2)
    );

    // Clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver: present one request, let one edge take it, sample #1 later.
    task automatic step(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    function automatic int clamp8(input int v);
        if (v < 0) return 0;
        if (v > 8) return 8;
        return v;
    endfunction

    function automatic int min8(input int v);
        return (v > 8) ? 8 : v;
    endfunction

    initial begin
        int peak;
        int peak2;
        logic [15:0] d;

        rst_n   = 1'b0;
        enable  = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", data_valid, 1'b0);
        check("rst_data", data_out, 16'h0000);
        check("rst_inflight", inflight, 4'd0);
        check("rst_inflight_l2", inflight2, 4'd0);
        rst_n = 1'b1;
        idle();

        // Write then read, single word
        step(1'b1, 1'b1, 16'h0010, 16'hBEEF);
        step(1'b1, 1'b0, 16'h0010, 16'h0000);
        check("wr_rd_inflight0", inflight, 4'd1);
        for (int k = 1; k <= 4; k++) begin
            idle();
            check("wr_rd_valid", data_valid, (k == 3));
            if (k == 3) check("wr_rd_data", data_out, 16'hBEEF);
            check("wr_rd_inflight", inflight, (k == 4) ? 4'd0 : 4'd1);
        end

        // Burst of 8, both builds observed together
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 16'(16'h0100 + 2*i), 16'(16'hA000 + i));
        peak  = 0;
        peak2 = 0;
        for (int t = 0; t < 12; t++) begin
            if (t < 8) begin
                exp_q.push_back(16'(16'hA000 + t));
                step(1'b1, 1'b0, 16'(16'h0100 + 2*t), 16'h0000);
            end else begin
                idle();
            end
            check("burst_valid", data_valid, (t >= 3 && t <= 10));
            if (data_valid) begin
                if (exp_q.size() == 0) begin
                    check("burst_extra_rsp", 32'd1, 32'd0);
                end else begin
                    d = exp_q.pop_front();
                    check("burst_data", data_out, d);
                end
            end
            check("burst_inflight", inflight, 4'(min8(t + 1) - clamp8(t - 3)));
            check("l2_valid", data_valid2, (t >= 1 && t <= 8));
            if (t >= 1 && t <= 8) check("l2_data", data_out2, 16'(16'hA000 + t - 1));
            check("l2_inflight", inflight2, 4'(min8(t + 1) - clamp8(t - 1)));
            if (int'(inflight) > peak) peak = int'(inflight);
            if (int'(inflight2) > peak2) peak2 = int'(inflight2);
        end
        check("burst_q_empty", exp_q.size(), 0);
        check("burst_peak", peak, 4);
        check("l2_peak", peak2, 2);

        // Read-before-write hazard
        step(1'b1, 1'b1, 16'h0040, 16'h1111);
        step(1'b1, 1'b0, 16'h0040, 16'h0000);
        step(1'b1, 1'b1, 16'h0040, 16'h2222);
        check("haz_valid", data_valid, 1'b0);
        step(1'b1, 1'b0, 16'h0040, 16'h0000);
        check("haz_valid", data_valid, 1'b0);
        for (int t = 3; t <= 6; t++) begin
            idle();
            check("haz_valid", data_valid, (t == 3 || t == 5));
            if (t == 3) check("haz_old", data_out, 16'h1111);
            if (t == 5) check("haz_new", data_out, 16'h2222);
        end

        // Bubbles and odd address
        step(1'b1, 1'b1, 16'h0020, 16'h5A5A);
        step(1'b1, 1'b0, 16'h0021, 16'h0000);
        idle();
        check("odd_valid", data_valid, 1'b0);
        step(1'b1, 1'b0, 16'h0021, 16'h0000);
        check("odd_valid", data_valid, 1'b0);
        for (int t = 3; t <= 6; t++) begin
            idle();
            check("odd_valid", data_valid, (t == 3 || t == 5));
            if (t == 3 || t == 5) check("odd_data", data_out, 16'h5A5A);
        end

        // Reset mid-flight
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0010, 16'h0000);
        enable = 1'b0;
        rst_n  = 1'b0;
        #2;
        check("midrst_valid", data_valid, 1'b0);
        check("midrst_data", data_out, 16'h0000);
        check("midrst_inflight", inflight, 4'd0);
        check("midrst_inflight_l2", inflight2, 4'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            idle();
            check("midrst_no_rsp", data_valid, 1'b0);
            check("midrst_no_rsp_l2", data_valid2, 1'b0);
            check("midrst_inflight_after", inflight, 4'd0);
        end
        step(1'b1, 1'b0, 16'h0010, 16'h0000);
        for (int k = 1; k <= 3; k++) begin
            idle();
            check("retain_valid", data_valid, (k == 3));
        end
        check("retain_data", data_out, 16'hBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
